// File: rtl/simd_product_accumulator.sv
// simd_product_accumulator: sums a programmable-length group of unsigned
// multiplier products and presents each group sum over a valid/ready output
// with a sticky per-group overflow flag.
module simd_product_accumulator #(
   parameter int unsigned PROD_W = 8,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_product,
   input  logic [CNT_W-1:0]  len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_overflow
);

   localparam int unsigned SUM_W = ACC_W + 1;
   localparam int unsigned CMP_W = CNT_W + 1;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ACC_W-1:0]   acc;
   logic               ovf;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   len_q;

   logic               accept;
   logic [CNT_W-1:0]   len_first;
   logic [CNT_W-1:0]   eff;
   logic [CMP_W-1:0]   count_inc;
   logic               last;
   logic [SUM_W-1:0]   sum_ext;
   logic               carry;

   // Ready is a pure decode of the state register.
   assign in_ready  = (state == ACCUM);
   assign accept    = in_valid && in_ready;

   // A zero length is promoted to one; later beats use the latched length.
   assign len_first = (len == '0) ? CNT_W'(1) : len;
   assign eff       = (count == '0) ? len_first : len_q;
   assign count_inc = CMP_W'(count) + CMP_W'(1);
   assign last      = (count_inc == CMP_W'(eff));

   // One extra bit on the add exposes the carry out of the accumulator.
   assign sum_ext   = SUM_W'(acc) + SUM_W'(in_product);
   assign carry     = sum_ext[ACC_W];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: leave ACCUM on the last beat, leave HOLD on the output handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: begin
            if (accept && last) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt = ACCUM;
            end
         end
         default: begin
            state_nxt = ACCUM;
         end
      endcase
   end

   // Accumulator datapath and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         ovf          <= 1'b0;
         count        <= '0;
         len_q        <= '0;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_overflow <= 1'b0;
      end else if (accept) begin
         if (count == '0) begin
            len_q <= len_first;
         end
         if (last) begin
            out_sum      <= sum_ext[ACC_W-1:0];
            out_overflow <= ovf | carry;
            out_valid    <= 1'b1;
            acc          <= '0;
            ovf          <= 1'b0;
            count        <= '0;
         end else begin
            acc   <= sum_ext[ACC_W-1:0];
            ovf   <= ovf | carry;
            count <= count_inc[CNT_W-1:0];
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_simd_product_accumulator.sv
// Self-checking bench for simd_product_accumulator: two instances (16-bit and
// 10-bit accumulators) share stimulus and are checked against a group-level
// integer model every cycle, plus directed scenarios with literal results.
module tb_simd_product_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_product;
   logic [3:0] len;
   logic       out_ready;

   logic        in_ready16, out_valid16, out_overflow16;
   logic [15:0] out_sum16;
   logic        in_ready10, out_valid10, out_overflow10;
   logic [9:0]  out_sum10;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Group-level model: integer total of the group, overflow derived at the end.
   bit m_hold  = 1'b0;
   int m_total = 0;
   int m_n     = 0;
   int m_target = 0;
   int m_sum   = 0;

   always #5 clk = ~clk;

   simd_product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) u16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
      .in_product(in_product), .len(len), .out_valid(out_valid16),
      .out_ready(out_ready), .out_sum(out_sum16), .out_overflow(out_overflow16)
   );

   simd_product_accumulator #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) u10 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10),
      .in_product(in_product), .len(len), .out_valid(out_valid10),
      .out_ready(out_ready), .out_sum(out_sum10), .out_overflow(out_overflow10)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_len(input logic [3:0] l);
      return (l == 4'd0) ? 1 : int'(l);
   endfunction

   // Reference model advances on each rising edge from the sampled inputs.
   always @(posedge clk) begin
      if (rst) begin
         m_hold   <= 1'b0;
         m_total  <= 0;
         m_n      <= 0;
         m_target <= 0;
         m_sum    <= 0;
      end else if (m_hold) begin
         if (out_ready) m_hold <= 1'b0;
      end else if (in_valid) begin
         if (((m_n == 0) ? first_len(len) : m_target) == m_n + 1) begin
            m_hold  <= 1'b1;
            m_sum   <= m_total + int'(in_product);
            m_total <= 0;
            m_n     <= 0;
         end else begin
            m_total <= m_total + int'(in_product);
            m_n     <= m_n + 1;
            if (m_n == 0) m_target <= first_len(len);
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready16", 32'(in_ready16), 32'(!m_hold));
         chk("out_valid16", 32'(out_valid16), 32'(m_hold));
         chk("in_ready10", 32'(in_ready10), 32'(!m_hold));
         chk("out_valid10", 32'(out_valid10), 32'(m_hold));
         if (m_hold) begin
            chk("out_sum16", 32'(out_sum16), 32'(m_sum % 65536));
            chk("out_overflow16", 32'(out_overflow16), 32'(m_sum >= 65536));
            chk("out_sum10", 32'(out_sum10), 32'(m_sum % 1024));
            chk("out_overflow10", 32'(out_overflow10), 32'(m_sum >= 1024));
         end
      end
   end

   // Offer one beat at a falling edge and return at the falling edge after it is taken.
   task automatic send(input int p, input int l);
      in_valid   = 1'b1;
      in_product = 8'(p);
      len        = 4'(l);
      for (int k = 0; k < 40 && !in_ready16; k++) @(negedge clk);
      chk("send_accepted", 32'(in_ready16), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for a result, pin it to hand-computed values, optionally acknowledge.
   task automatic get_result(input int s16, input int o16, input int s10, input int o10,
                             input bit ack);
      for (int k = 0; k < 40 && !out_valid16; k++) @(negedge clk);
      chk("lit_valid", 32'(out_valid16), 32'd1);
      chk("lit_sum16", 32'(out_sum16), 32'(s16));
      chk("lit_ovf16", 32'(out_overflow16), 32'(o16));
      chk("lit_sum10", 32'(out_sum10), 32'(s10));
      chk("lit_ovf10", 32'(out_overflow10), 32'(o10));
      if (ack) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_product = '0; len = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid16), 32'd0);
      chk("rst_in_ready", 32'(in_ready16), 32'd1);
      chk("rst_out_sum", 32'(out_sum16), 32'd0);
      chk("rst_out_overflow", 32'(out_overflow16), 32'd0);

      // Four back-to-back 225s.
      repeat (4) send(225, 4);
      get_result(900, 0, 900 % 1024, 0, 1'b0);

      // Backpressure with a beat offered during HOLD.
      in_valid = 1'b1; in_product = 8'd7; len = 4'd1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_sum_stable", 32'(out_sum16), 32'd900);
         chk("bp_in_ready", 32'(in_ready16), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_valid_drop", 32'(out_valid16), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      get_result(7, 0, 7, 0, 1'b1);

      // Zero length and mid-group length change.
      send(9, 0);
      get_result(9, 0, 9, 0, 1'b1);
      send(10, 2);
      send(20, 3);
      get_result(30, 0, 30, 0, 1'b1);

      // Wrap on the narrow accumulator, then flag clears on the next group.
      repeat (5) send(225, 5);
      get_result(1125, 0, 101, 1, 1'b1);
      send(1, 1);
      get_result(1, 0, 1, 0, 1'b1);

      // Gapped input.
      send(5, 3);
      repeat (4) begin
         @(negedge clk);
         chk("gap_no_result", 32'(out_valid16), 32'd0);
      end
      send(6, 3);
      repeat (2) begin
         @(negedge clk);
         chk("gap_no_result", 32'(out_valid16), 32'd0);
      end
      send(7, 3);
      get_result(18, 0, 18, 0, 1'b1);

      // Reset mid-group discards the partial sum.
      send(100, 4);
      send(100, 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(1, 2);
      send(2, 2);
      get_result(3, 0, 3, 0, 1'b1);

      // Reset while holding a result.
      send(4, 1);
      get_result(4, 0, 4, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_in_hold", 32'(out_valid16), 32'd0);

      // Longest group: fifteen maximum products.
      repeat (15) send(255, 15);
      get_result(3825, 0, 3825 % 1024, 1, 1'b1);

      // Randomized traffic checked by the every-cycle model comparison.
      for (int c = 0; c < 600; c++) begin
         rst        = ($urandom_range(0, 149) == 0);
         in_valid   = ($urandom_range(0, 3) != 0);
         in_product = 8'($urandom_range(128, 255));
         if ($urandom_range(0, 3) == 0) in_product = 8'($urandom_range(0, 255));
         len        = 4'($urandom_range(0, 15));
         out_ready  = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
